cache_fill_ctrl: RTL

- Miss handler between the split I/D caches and the shared multi-cycle main memory in the pipelined 16-bit CPU.
- Accepts a miss from either cache and fetches the full block from memory as a sequence of pipelined word reads.
- Writes each returned word into the missing cache, then writes the tag/valid bit and pulses done.
- The pipeline stalls on fill_busy; the cpu_two trace counters derive I/D cache request and hit events from the miss inputs and done pulses.

---
 rtl/cache_fill_ctrl_if.sv | 49 ++++
 rtl/cache_fill_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl_if.sv
// Miss/memory/fill bundle between the split I/D caches, main memory and cache_fill_ctrl.
// master = fill controller side, slave = caches + memory side.
interface cache_fill_ctrl_if #(
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned WORDS_PER_BLOCK = 8
);
    localparam int unsigned IDX_W = $clog2(WORDS_PER_BLOCK);

    logic              icache_miss;
    logic [ADDR_W-1:0] icache_miss_addr;
    logic              dcache_miss;
    logic [ADDR_W-1:0] dcache_miss_addr;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_data_valid;
    logic [15:0]       mem_data_in;

    logic              icache_data_we;
    logic              dcache_data_we;
    logic [IDX_W-1:0]  fill_word_idx;
    logic [15:0]       fill_data;
    logic [ADDR_W-1:0] fill_block_addr;
    logic              icache_tag_we;
    logic              dcache_tag_we;
    logic              icache_fill_done;
    logic              dcache_fill_done;
    logic              fill_busy;
    logic [15:0]       ifill_count;
    logic [15:0]       dfill_count;

    modport master (
        input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
        input  mem_data_valid, mem_data_in,
        output mem_en, mem_addr,
        output icache_data_we, dcache_data_we, fill_word_idx, fill_data, fill_block_addr,
        output icache_tag_we, dcache_tag_we, icache_fill_done, dcache_fill_done,
        output fill_busy, ifill_count, dfill_count
    );

    modport slave (
        output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
        output mem_data_valid, mem_data_in,
        input  mem_en, mem_addr,
        input  icache_data_we, dcache_data_we, fill_word_idx, fill_data, fill_block_addr,
        input  icache_tag_we, dcache_tag_we, icache_fill_done, dcache_fill_done,
        input  fill_busy, ifill_count, dfill_count
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache miss handler: fetches a whole block from pipelined main memory into the I- or D-cache.
// Optional fill statistics counters are enabled by defining FILL_STATS_EN.
module cache_fill_ctrl #(
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned MEM_LATENCY     = 4
) (
    input  logic clk,
    input  logic rst,
    cache_fill_ctrl_if.master bus
);
    localparam int unsigned IDX_W   = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned OFF_W   = $clog2(2 * WORDS_PER_BLOCK);
    localparam int unsigned DRAIN_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(WORDS_PER_BLOCK - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE     = IDX_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST  = DRAIN_W'(MEM_LATENCY - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE   = DRAIN_W'(1);
    localparam logic [ADDR_W-1:0]  BLOCK_MASK  = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [ADDR_W-1:0]  WORD_STRIDE = ADDR_W'(2);

    typedef enum logic [1:0] {
        S_DRAIN = 2'd0,
        S_IDLE  = 2'd1,
        S_REQ   = 2'd2,
        S_WAIT  = 2'd3
    } fillState_t;

    fillState_t        state;
    logic              targetD;
    logic [IDX_W-1:0]  reqCnt;
    logic [IDX_W-1:0]  retCnt;
    logic [DRAIN_W-1:0] drainCnt;
    logic              memEn;
    logic [ADDR_W-1:0] memAddr;
    logic [ADDR_W-1:0] blockAddr;

    logic              missAny;
    logic [ADDR_W-1:0] missBase;
    logic              retValid;
    logic              lastRet;

    // Miss selection: D-side wins when both caches miss together.
    assign missAny  = bus.dcache_miss | bus.icache_miss;
    assign missBase = (bus.dcache_miss ? bus.dcache_miss_addr : bus.icache_miss_addr) & BLOCK_MASK;

    // Returns only count while a fill owns memory; DRAIN and IDLE discard them.
    assign retValid = bus.mem_data_valid && ((state == S_REQ) || (state == S_WAIT));
    assign lastRet  = retValid && (retCnt == LAST_IDX);

    // Fill sequencer: request issue, return counting and stale-read drain after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_DRAIN;
            targetD   <= 1'b0;
            reqCnt    <= '0;
            retCnt    <= '0;
            drainCnt  <= '0;
            memEn     <= 1'b0;
            memAddr   <= '0;
            blockAddr <= '0;
        end else begin
            case (state)
                S_DRAIN: begin
                    if (drainCnt == DRAIN_LAST) begin
                        drainCnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        drainCnt <= drainCnt + DRAIN_ONE;
                    end
                end
                S_IDLE: begin
                    if (missAny) begin
                        targetD   <= bus.dcache_miss;
                        blockAddr <= missBase;
                        memEn     <= 1'b1;
                        memAddr   <= missBase;
                        reqCnt    <= '0;
                        retCnt    <= '0;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (reqCnt == LAST_IDX) begin
                        memEn   <= 1'b0;
                        memAddr <= '0;
                        reqCnt  <= '0;
                        state   <= S_WAIT;
                    end else begin
                        reqCnt  <= reqCnt + IDX_ONE;
                        memAddr <= memAddr + WORD_STRIDE;
                    end
                end
                S_WAIT: begin
                    state <= S_WAIT;
                end
                default: begin
                    state <= S_DRAIN;
                end
            endcase

            // Returns may overlap the request burst; the final one closes the fill.
            if (retValid) begin
                if (lastRet) begin
                    retCnt  <= '0;
                    reqCnt  <= '0;
                    memEn   <= 1'b0;
                    memAddr <= '0;
                    state   <= S_IDLE;
                end else begin
                    retCnt <= retCnt + IDX_ONE;
                end
            end
        end
    end

    // Write path is a same-cycle decode of the returning word so the cache sees it with no extra latency.
    assign bus.mem_en           = memEn;
    assign bus.mem_addr         = memAddr;
    assign bus.icache_data_we   = retValid && !targetD;
    assign bus.dcache_data_we   = retValid && targetD;
    assign bus.fill_word_idx    = retCnt;
    assign bus.fill_data        = retValid ? bus.mem_data_in : 16'h0000;
    assign bus.fill_block_addr  = blockAddr;
    assign bus.icache_tag_we    = lastRet && !targetD;
    assign bus.dcache_tag_we    = lastRet && targetD;
    assign bus.icache_fill_done = lastRet && !targetD;
    assign bus.dcache_fill_done = lastRet && targetD;
    assign bus.fill_busy        = (state != S_IDLE);

`ifdef FILL_STATS_EN
    logic [15:0] iFillCnt;
    logic [15:0] dFillCnt;

    // Saturating per-cache fill counters, bumped on each completed fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            iFillCnt <= 16'h0000;
            dFillCnt <= 16'h0000;
        end else begin
            if (lastRet && !targetD && (iFillCnt != 16'hFFFF)) begin
                iFillCnt <= iFillCnt + 16'd1;
            end
            if (lastRet && targetD && (dFillCnt != 16'hFFFF)) begin
                dFillCnt <= dFillCnt + 16'd1;
            end
        end
    end

    assign bus.ifill_count = iFillCnt;
    assign bus.dfill_count = dFillCnt;
`else
    assign bus.ifill_count = 16'h0000;
    assign bus.dfill_count = 16'h0000;
`endif

endmodule
